// File: rtl/coms_master.sv
// RS485 bus master: builds status-poll / setpoint frames, streams them to the
// UART transmitter, then hunts for and validates the 28-byte status response.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start_status / start_setpoint
// BUILD      | frame latched, CRC folded in one byte per cycle
// SEND       | driver enabled, bytes handed to the UART one at a time
// WAIT_MAGIC | sliding 4-byte window looking for 1C EB 00 DA
// RECEIVE    | storing the 24 bytes that follow the magic number
// CHECK      | CRC over stored bytes 0..21, compare CRC and board ID
module coms_master #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start_status,
    input  logic               start_setpoint,
    input  logic [7:0]         target_id,
    input  logic signed [23:0] setpoint_cmd,
    input  logic [23:0]        color_cmd,
    output logic [7:0]         tx_data,
    output logic               tx_transmit,
    input  logic               tx_active,
    input  logic               tx_done,
    input  logic               rx_data_ready,
    input  logic [7:0]         rx_data,
    output logic               driver_enable,
    output logic               busy,
    output logic               status_valid,
    output logic               crc_error,
    output logic               timeout,
    output logic [7:0]         rsp_id,
    output logic [7:0]         rsp_control_mode,
    output logic signed [23:0] rsp_enc0,
    output logic signed [23:0] rsp_enc1,
    output logic signed [23:0] rsp_setpoint,
    output logic signed [23:0] rsp_duty,
    output logic signed [23:0] rsp_displacement,
    output logic signed [15:0] rsp_current,
    output logic [23:0]        rsp_color
);

    typedef enum logic [2:0] {IDLE, BUILD, SEND, WAIT_MAGIC, RECEIVE, CHECK} state_t;

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [31:0] RSP_MAGIC = 32'h1CEB00DA;

    state_t        state, state_nxt;
    logic          is_status;
    logic [7:0]    tgt_id;
    logic [7:0]    frame_buf [13];
    logic [7:0]    rx_buf [24];
    logic [3:0]    tx_idx, build_idx;
    logic [4:0]    rx_cnt, chk_idx;
    logic [15:0]   crc, crc_step;
    logic [7:0]    crc_data;
    logic          tx_started, tx_pending;
    logic          rx_ready_d, rx_strobe;
    logic [31:0]   window, win_next;
    logic [TW-1:0] tmr;
    logic [3:0]    payload_last, frame_last;

    // MSB-first CRC-16, polynomial 0x8005, one byte folded in
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    assign payload_last  = is_status ? 4'd4 : 4'd10;
    assign frame_last    = is_status ? 4'd6 : 4'd12;
    assign crc_data      = (state == CHECK) ? rx_buf[chk_idx] : frame_buf[build_idx];
    assign crc_step      = crc16_byte(crc, crc_data);
    assign rx_strobe     = rx_data_ready & ~rx_ready_d;
    assign win_next      = {window[23:0], rx_data};
    assign tx_data       = frame_buf[tx_idx];
    assign busy          = (state != IDLE);
    assign driver_enable = (state == SEND);

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and transmit strobe
    always_comb begin
        state_nxt   = state;
        tx_transmit = 1'b0;
        case (state)
            IDLE:       if (start_status || start_setpoint) state_nxt = BUILD;
            BUILD:      if (build_idx == payload_last) state_nxt = SEND;
            SEND: begin
                if ((!tx_started && !tx_active) || tx_pending) tx_transmit = 1'b1;
                if (tx_done && tx_started && tx_idx == frame_last)
                    state_nxt = is_status ? WAIT_MAGIC : IDLE;
            end
            WAIT_MAGIC: begin
                if (rx_strobe) begin
                    if (win_next == RSP_MAGIC) state_nxt = RECEIVE;
                end else if (tmr == TW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            RECEIVE: begin
                if (rx_strobe) begin
                    if (rx_cnt == 5'd23) state_nxt = CHECK;
                end else if (tmr == TW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            CHECK:      if (chk_idx == 5'd22) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Frame buffers, CRC engine, timeout down-counter and result registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            is_status        <= 1'b0;
            tgt_id           <= '0;
            for (int i = 0; i < 13; i++) frame_buf[i] <= '0;
            for (int i = 0; i < 24; i++) rx_buf[i] <= '0;
            tx_idx           <= '0;
            build_idx        <= '0;
            rx_cnt           <= '0;
            chk_idx          <= '0;
            crc              <= 16'hFFFF;
            tx_started       <= 1'b0;
            tx_pending       <= 1'b0;
            rx_ready_d       <= 1'b0;
            window           <= '0;
            tmr              <= '0;
            status_valid     <= 1'b0;
            crc_error        <= 1'b0;
            timeout          <= 1'b0;
            rsp_id           <= '0;
            rsp_control_mode <= '0;
            rsp_enc0         <= '0;
            rsp_enc1         <= '0;
            rsp_setpoint     <= '0;
            rsp_duty         <= '0;
            rsp_displacement <= '0;
            rsp_current      <= '0;
            rsp_color        <= '0;
        end else begin
            rx_ready_d   <= rx_data_ready;
            status_valid <= 1'b0;
            crc_error    <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_status || start_setpoint) begin
                        is_status  <= start_status;
                        tgt_id     <= target_id;
                        build_idx  <= 4'd4;
                        crc        <= 16'hFFFF;
                        tx_idx     <= '0;
                        tx_started <= 1'b0;
                        tx_pending <= 1'b0;
                        frame_buf[4] <= target_id;
                        if (start_status) begin
                            frame_buf[0] <= 8'h1C;
                            frame_buf[1] <= 8'hE1;
                            frame_buf[2] <= 8'hCE;
                            frame_buf[3] <= 8'hBB;
                        end else begin
                            for (int i = 0; i < 4; i++) frame_buf[i] <= 8'hD0;
                            frame_buf[5]  <= setpoint_cmd[23:16];
                            frame_buf[6]  <= setpoint_cmd[15:8];
                            frame_buf[7]  <= setpoint_cmd[7:0];
                            frame_buf[8]  <= color_cmd[23:16];
                            frame_buf[9]  <= color_cmd[15:8];
                            frame_buf[10] <= color_cmd[7:0];
                        end
                    end
                end
                BUILD: begin
                    crc       <= crc_step;
                    build_idx <= build_idx + 4'd1;
                    if (build_idx == payload_last) begin
                        frame_buf[payload_last + 4'd1] <= crc_step[15:8];
                        frame_buf[payload_last + 4'd2] <= crc_step[7:0];
                    end
                end
                SEND: begin
                    if (tx_transmit) begin
                        tx_started <= 1'b1;
                        tx_pending <= 1'b0;
                    end
                    if (tx_done && tx_started) begin
                        if (tx_idx != frame_last) begin
                            tx_idx     <= tx_idx + 4'd1;
                            tx_pending <= 1'b1;
                        end else begin
                            window <= '0;
                            tmr    <= TMR_LOAD;
                        end
                    end
                end
                WAIT_MAGIC: begin
                    if (rx_strobe) begin
                        window <= win_next;
                        tmr    <= TMR_LOAD;
                        rx_cnt <= '0;
                    end else if (tmr == TW'(1)) begin
                        timeout <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                RECEIVE: begin
                    if (rx_strobe) begin
                        rx_buf[rx_cnt] <= rx_data;
                        rx_cnt         <= rx_cnt + 5'd1;
                        tmr            <= TMR_LOAD;
                        if (rx_cnt == 5'd23) begin
                            crc     <= 16'hFFFF;
                            chk_idx <= '0;
                        end
                    end else if (tmr == TW'(1)) begin
                        timeout <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                CHECK: begin
                    if (chk_idx != 5'd22) begin
                        crc     <= crc_step;
                        chk_idx <= chk_idx + 5'd1;
                    end else if ({rx_buf[22], rx_buf[23]} == crc && rx_buf[0] == tgt_id) begin
                        status_valid     <= 1'b1;
                        rsp_id           <= rx_buf[0];
                        rsp_control_mode <= rx_buf[1];
                        rsp_enc0         <= {rx_buf[2], rx_buf[3], rx_buf[4]};
                        rsp_enc1         <= {rx_buf[5], rx_buf[6], rx_buf[7]};
                        rsp_setpoint     <= {rx_buf[8], rx_buf[9], rx_buf[10]};
                        rsp_duty         <= {rx_buf[11], rx_buf[12], rx_buf[13]};
                        rsp_displacement <= {rx_buf[14], rx_buf[15], rx_buf[16]};
                        rsp_current      <= {rx_buf[17], rx_buf[18]};
                        rsp_color        <= {rx_buf[19], rx_buf[20], rx_buf[21]};
                    end else begin
                        crc_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coms_master.sv
// Directed bench for coms_master: frame bytes, response decode, CRC/ID
// rejection, setpoint write, timeout timing and mid-frame reset.
module tb_coms_master;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               start_status = 1'b0, start_setpoint = 1'b0;
    logic [7:0]         target_id = 8'h01;
    logic signed [23:0] setpoint_cmd = '0;
    logic [23:0]        color_cmd = '0;
    logic [7:0]         tx_data;
    logic               tx_transmit;
    logic               tx_active = 1'b0, tx_done = 1'b0;
    logic               rx_data_ready = 1'b0;
    logic [7:0]         rx_data = '0;
    logic               driver_enable, busy, status_valid, crc_error, timeout;
    logic [7:0]         rsp_id, rsp_control_mode;
    logic signed [23:0] rsp_enc0, rsp_enc1, rsp_setpoint, rsp_duty, rsp_displacement;
    logic signed [15:0] rsp_current;
    logic [23:0]        rsp_color;

    int checks = 0, failures = 0;
    logic [7:0] cap [16];
    int proto_bad;
    logic [7:0] resp [24];
    int n_sv, n_ce;

    coms_master #(.TIMEOUT_CYCLES(100)) dut (
        .CLK(CLK), .reset(reset),
        .start_status(start_status), .start_setpoint(start_setpoint),
        .target_id(target_id), .setpoint_cmd(setpoint_cmd), .color_cmd(color_cmd),
        .tx_data(tx_data), .tx_transmit(tx_transmit),
        .tx_active(tx_active), .tx_done(tx_done),
        .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .driver_enable(driver_enable), .busy(busy),
        .status_valid(status_valid), .crc_error(crc_error), .timeout(timeout),
        .rsp_id(rsp_id), .rsp_control_mode(rsp_control_mode),
        .rsp_enc0(rsp_enc0), .rsp_enc1(rsp_enc1), .rsp_setpoint(rsp_setpoint),
        .rsp_duty(rsp_duty), .rsp_displacement(rsp_displacement),
        .rsp_current(rsp_current), .rsp_color(rsp_color)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: bitwise LFSR, poly x^16+x^15+x^2+1, MSB first
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    // UART transmitter stand-in: accept each strobe, answer with tx_done later
    task automatic run_tx(input int n);
        int w;
        proto_bad = 0;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (tx_transmit !== 1'b1 && w < 20) begin tick; w++; end
            if (w >= 20) begin
                chk("tx_strobe_wait", 32'(tx_transmit), 32'd1);
                return;
            end
            cap[b] = tx_data;
            if (driver_enable !== 1'b1) proto_bad++;
            tick;
            if (tx_transmit !== 1'b0) proto_bad++;
            tick;
            tx_done = 1'b1;
            if (driver_enable !== 1'b1) proto_bad++;
            tick;
            tx_done = 1'b0;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_data_ready = 1'b1;
        tick;
        tick;
        rx_data_ready = 1'b0;
        tick;
    endtask

    task automatic build_resp(input logic [7:0] id, input logic [23:0] enc0, input logic [15:0] cur, input logic flip);
        logic [15:0] c;
        resp[0] = id;       resp[1] = 8'h02;
        resp[2] = enc0[23:16]; resp[3] = enc0[15:8]; resp[4] = enc0[7:0];
        resp[5] = 8'h00; resp[6] = 8'h04; resp[7] = 8'h56;
        resp[8] = 8'hFF; resp[9] = 8'hFF; resp[10] = 8'h9C;
        resp[11] = 8'h00; resp[12] = 8'h02; resp[13] = 8'h00;
        resp[14] = 8'h12; resp[15] = 8'h34; resp[16] = 8'h56;
        resp[17] = cur[15:8]; resp[18] = cur[7:0];
        resp[19] = 8'hAB; resp[20] = 8'hCD; resp[21] = 8'hEF;
        c = 16'hFFFF;
        for (int i = 0; i < 22; i++) c = crc_bit(c, resp[i]);
        resp[22] = c[15:8]; resp[23] = c[7:0];
        if (flip) resp[6] = resp[6] ^ 8'h10;
    endtask

    task automatic send_resp(input int nbytes, input logic noise);
        if (noise) begin rx_byte(8'h55); rx_byte(8'hAA); end
        rx_byte(8'h1C); rx_byte(8'hEB); rx_byte(8'h00); rx_byte(8'hDA);
        for (int i = 0; i < nbytes; i++) rx_byte(resp[i]);
    endtask

    task automatic wait_result;
        n_sv = 0; n_ce = 0;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (status_valid === 1'b1) n_sv++;
            if (crc_error === 1'b1) n_ce++;
        end
    endtask

    task automatic poll01;
        target_id = 8'h01;
        start_status = 1'b1;
        tick;
        start_status = 1'b0;
        run_tx(7);
    endtask

    initial begin
        logic [7:0]  stat_exp [7];
        logic [7:0]  sp_exp [13];
        logic [15:0] c;
        int          kto;

        stat_exp = '{8'h1C, 8'hE1, 8'hCE, 8'hBB, 8'h01, 8'h7D, 8'h07};

        // reset state
        tick; tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_de", 32'(driver_enable), 32'd0);
        chk("rst_tx_transmit", 32'(tx_transmit), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_pulses", {29'd0, status_valid, crc_error, timeout}, 32'd0);
        chk("rst_enc0", {8'd0, rsp_enc0}, 32'd0);
        reset = 1'b0;
        tick;

        // status poll to board 01
        poll01;
        for (int i = 0; i < 7; i++) chk($sformatf("stat_byte%0d", i), 32'(cap[i]), 32'(stat_exp[i]));
        chk("stat_proto", 32'(proto_bad), 32'd0);
        chk("stat_wait_busy", 32'(busy), 32'd1);
        chk("stat_wait_de", 32'(driver_enable), 32'd0);

        // valid response preceded by noise
        build_resp(8'h01, 24'h000123, 16'hFF38, 1'b0);
        send_resp(24, 1'b1);
        wait_result;
        chk("ok_sv_count", 32'(n_sv), 32'd1);
        chk("ok_ce_count", 32'(n_ce), 32'd0);
        chk("ok_id", 32'(rsp_id), 32'h01);
        chk("ok_mode", 32'(rsp_control_mode), 32'h02);
        chk("ok_enc0", {8'd0, rsp_enc0}, 32'h000123);
        chk("ok_enc1", {8'd0, rsp_enc1}, 32'h000456);
        chk("ok_setpoint", {8'd0, rsp_setpoint}, 32'hFFFF9C);
        chk("ok_duty", {8'd0, rsp_duty}, 32'h000200);
        chk("ok_disp", {8'd0, rsp_displacement}, 32'h123456);
        chk("ok_current", {16'd0, rsp_current}, 32'h0000FF38);
        chk("ok_color", {8'd0, rsp_color}, 32'hABCDEF);
        chk("ok_idle", 32'(busy), 32'd0);

        // corrupted payload bit
        poll01;
        build_resp(8'h01, 24'h000999, 16'h0001, 1'b1);
        send_resp(24, 1'b0);
        wait_result;
        chk("flip_ce_count", 32'(n_ce), 32'd1);
        chk("flip_sv_count", 32'(n_sv), 32'd0);
        chk("flip_enc0_kept", {8'd0, rsp_enc0}, 32'h000123);
        chk("flip_current_kept", {16'd0, rsp_current}, 32'h0000FF38);

        // wrong board ID with a correct CRC
        poll01;
        build_resp(8'h02, 24'h000777, 16'h0002, 1'b0);
        send_resp(24, 1'b0);
        wait_result;
        chk("id_ce_count", 32'(n_ce), 32'd1);
        chk("id_sv_count", 32'(n_sv), 32'd0);
        chk("id_enc0_kept", {8'd0, rsp_enc0}, 32'h000123);
        chk("id_rsp_id_kept", 32'(rsp_id), 32'h01);

        // setpoint write
        target_id = 8'h05;
        setpoint_cmd = 24'hFFFF9C;
        color_cmd = 24'h00FF00;
        sp_exp = '{8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'h05, 8'hFF, 8'hFF, 8'h9C, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
        c = 16'hFFFF;
        for (int i = 4; i < 11; i++) c = crc_bit(c, sp_exp[i]);
        sp_exp[11] = c[15:8];
        sp_exp[12] = c[7:0];
        start_setpoint = 1'b1;
        tick;
        start_setpoint = 1'b0;
        run_tx(13);
        for (int i = 0; i < 13; i++) chk($sformatf("sp_byte%0d", i), 32'(cap[i]), 32'(sp_exp[i]));
        chk("sp_proto", 32'(proto_bad), 32'd0);
        chk("sp_idle_after", 32'(busy), 32'd0);
        chk("sp_de_after", 32'(driver_enable), 32'd0);

        // simultaneous starts: status wins; then silent bus -> timeout
        target_id = 8'h01;
        start_status = 1'b1;
        start_setpoint = 1'b1;
        tick;
        start_status = 1'b0;
        start_setpoint = 1'b0;
        run_tx(7);
        chk("both_len_byte0", 32'(cap[0]), 32'h1C);
        chk("both_byte6", 32'(cap[6]), 32'h07);
        kto = -1;
        for (int k = 1; k <= 300; k++) begin
            start_setpoint = (k == 10);
            tick;
            if (timeout === 1'b1) begin kto = k; break; end
        end
        start_setpoint = 1'b0;
        chk("timeout_latency", 32'(kto), 32'd100);
        tick;
        chk("timeout_idle", 32'(busy), 32'd0);
        chk("timeout_pulse_once", 32'(timeout), 32'd0);

        // reset in the middle of RECEIVE, then a fresh poll
        poll01;
        build_resp(8'h01, 24'h000123, 16'hFF38, 1'b0);
        send_resp(10, 1'b0);
        chk("mid_rx_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_enc0", {8'd0, rsp_enc0}, 32'd0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mid_de", 32'(driver_enable), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        poll01;
        chk("post_rst_byte4", 32'(cap[4]), 32'h01);
        chk("post_rst_byte5", 32'(cap[5]), 32'h7D);
        send_resp(24, 1'b0);
        wait_result;
        chk("post_rst_sv_count", 32'(n_sv), 32'd1);
        chk("post_rst_enc0", {8'd0, rsp_enc0}, 32'h000123);
        chk("post_rst_current", {16'd0, rsp_current}, 32'h0000FF38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coms_master.md
COMS_MASTER -- requirements
Module: coms_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum number of CLK cycles to wait for a status response after the last request byte.
REQ-002 SHALL have port CLK, input, 1 bit: clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_status, input, 1 bit: one-cycle pulse that starts a status poll.
REQ-005 SHALL have port start_setpoint, input, 1 bit: one-cycle pulse that starts a setpoint write.
REQ-006 SHALL have port target_id, input, 8 bits: ID of the addressed board.
REQ-007 SHALL have port setpoint_cmd, input, 24 bits signed, and port color_cmd, input, 24 bits: the setpoint-frame payload.
REQ-008 SHALL have port tx_data, output, 8 bits: the byte presented to the UART transmitter.
REQ-009 SHALL have port tx_transmit, output, 1 bit: one-cycle send strobe.
REQ-010 SHALL have port tx_active, input, 1 bit, and port tx_done, input, 1 bit: transmitter busy flag and transmitter done pulse.
REQ-011 SHALL have port rx_data_ready, input, 1 bit, and port rx_data, input, 8 bits: receiver byte-valid level and received byte.
REQ-012 SHALL have port driver_enable, output, 1 bit: RS485 driver enable.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the block is not IDLE.
REQ-014 SHALL have ports status_valid, crc_error and timeout, outputs, 1 bit each: one-cycle result pulses.
REQ-015 SHALL have status-field outputs, registered: rsp_id 8, rsp_control_mode 8, rsp_enc0 24s, rsp_enc1 24s, rsp_setpoint 24s, rsp_duty 24s, rsp_displacement 24s, rsp_current 16s, rsp_color 24.

Function
REQ-016 CRC SHALL be CRC-16 with polynomial x^16+x^15+x^2+1, initial value 0xFFFF, data MSB first, no reflection and no final XOR; the CRC covers every byte after the magic number; the high CRC byte is sent first.
REQ-017 Status request frame SHALL be 1C E1 CE BB, target_id, CRC_hi, CRC_lo (7 bytes).
REQ-018 Setpoint frame SHALL be D0 D0 D0 D0, target_id, setpoint_cmd[23:16], [15:8], [7:0], color_cmd[23:16], [15:8], [7:0], CRC_hi, CRC_lo (13 bytes).
REQ-019 Status response frame SHALL be 1C EB 00 DA followed by: ID, control_mode, enc0, enc1, setpoint, duty, displacement (3 bytes each, MSB first), current (2 bytes), color (3 bytes), CRC (2 bytes); 28 bytes total.
REQ-020 The state machine SHALL have the states IDLE, BUILD, SEND, WAIT_MAGIC, RECEIVE, CHECK.
REQ-021 IDLE: start_status SHALL go to BUILD(status); start_setpoint SHALL go to BUILD(setpoint); if both are asserted in the same cycle, status SHALL win; start pulses arriving while busy SHALL be ignored.
REQ-022 BUILD SHALL latch target_id, setpoint_cmd and color_cmd into a frame buffer and compute the CRC one byte per cycle, then enter SEND.
REQ-023 SEND SHALL hold driver_enable=1.
REQ-023a SEND SHALL pulse tx_transmit for byte 0 when tx_active=0, and pulse it for each following byte on the cycle after tx_done.
REQ-023b When tx_done arrives for the last byte, SEND SHALL go to WAIT_MAGIC (status) or IDLE (setpoint).
REQ-024 A received byte SHALL be taken on the rising edge of rx_data_ready only; bytes seen outside WAIT_MAGIC or RECEIVE SHALL be discarded.
REQ-025 WAIT_MAGIC SHALL shift bytes into a 4-byte window and go to RECEIVE with byte count 0 when the window equals 1CEB00DA.
REQ-026 RECEIVE SHALL store 24 bytes, then go to CHECK.
REQ-027 CHECK SHALL compute the CRC over the first 22 stored bytes.
REQ-027a If the CRC matches bytes 22 and 23 and byte 0 equals the latched target_id, CHECK SHALL update all rsp_* outputs simultaneously and pulse status_valid for one cycle.
REQ-027b Otherwise CHECK SHALL pulse crc_error and leave rsp_* unchanged; in both cases the next state SHALL be IDLE.
REQ-028 The timeout counter SHALL restart on entry to WAIT_MAGIC and on every received byte; when it reaches TIMEOUT_CYCLES in WAIT_MAGIC or RECEIVE, the block SHALL pulse timeout and go to IDLE.
REQ-029 driver_enable SHALL be 0 in every state except SEND.

Reset
REQ-030 On reset the block SHALL go to IDLE immediately, including mid-frame, and drop the partial frame.
REQ-031 On reset tx_transmit, driver_enable, busy, status_valid, crc_error and timeout SHALL be 0.
REQ-032 On reset tx_data and all rsp_* outputs SHALL be 0, and the timeout counter and byte counters SHALL be cleared.

Verification
REQ-033 start_status with target_id=01 -> the bytes 1C E1 CE BB 01 7D 07 are sent, with driver_enable high from the first strobe until the last tx_done.
REQ-034 Status response from ID 01 with enc0=0x000123, current=0xFF38 and a valid CRC -> rsp_enc0=0x000123, rsp_current=-200, and status_valid pulses once.
REQ-035 The same response with one payload bit flipped -> crc_error pulses, rsp_* unchanged; a response carrying ID 02 -> crc_error pulses.
REQ-036 start_setpoint with setpoint_cmd=0xFFFF9C and color_cmd=0x00FF00 -> 13 bytes sent, bytes 5..10 = FF FF 9C 00 FF 00, then IDLE with no receive phase.
REQ-037 No response with TIMEOUT_CYCLES=100 -> timeout pulses 100 cycles after the last tx_done; noise bytes 55 AA ahead of the magic are ignored.
REQ-038 reset asserted mid-RECEIVE, then a fresh poll -> the block returns to IDLE with outputs zeroed, and the next poll completes normally.
